// File: rtl/coin_collector_chg.sv
// coin_collector_chg: vending-machine coin collector with configurable price.
// Accumulates credit from 2-bit coin codes, holds done until the dispense unit
// acknowledges, then returns any surplus (or the whole credit on cancel) as
// one 25p change_pulse per cycle. All outputs come straight from flops.
module coin_collector_chg #(
    parameter int PRICE      = 100,
    parameter int MAX_CREDIT = 175,
    parameter int CW         = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    coin,
    input  logic          cancel,
    input  logic          vend_ack,
    output logic          done,
    output logic [CW-1:0] credit,
    output logic          change_pulse,
    output logic          refunding,
    output logic          coin_reject,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE,
        REFUND
    } state_t;

    // The sum is formed one bit wider than the credit register so an
    // overflowing coin can be detected instead of wrapping.
    localparam logic [CW:0]   PRICE_WIDE   = (CW+1)'(PRICE);
    localparam logic [CW:0]   MAX_WIDE     = (CW+1)'(MAX_CREDIT);
    localparam logic [CW-1:0] PRICE_NARROW = CW'(PRICE);
    localparam logic [CW-1:0] CHANGE_STEP  = CW'(25);
    localparam logic [CW:0]   COIN_25      = (CW+1)'(25);
    localparam logic [CW:0]   COIN_50      = (CW+1)'(50);
    localparam logic [CW:0]   COIN_100     = (CW+1)'(100);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] credit_next;
    logic          done_next;
    logic          change_pulse_next;
    logic          refunding_next;
    logic          coin_reject_next;
    logic          busy_next;

    logic [CW:0]   coin_value;
    logic [CW:0]   credit_sum;
    logic          coin_valid;
    logic          coin_accepted;

    // Translate the coin code into its value in paise.
    always_comb begin
        coin_value = '0;
        case (coin)
            2'b00:   coin_value = COIN_25;
            2'b01:   coin_value = COIN_50;
            2'b10:   coin_value = COIN_100;
            default: coin_value = '0;
        endcase
    end

    assign coin_valid = (coin != 2'b11);
    assign credit_sum = {1'b0, credit} + coin_value;

    // A coin is credited only while collecting, only if it fits under the
    // credit ceiling, and never on the same edge as a cancel in COLLECT.
    // In IDLE cancel has nothing to refund, so it does not block a coin.
    assign coin_accepted = coin_valid
                         && (credit_sum <= MAX_WIDE)
                         && ((state == IDLE) || ((state == COLLECT) && !cancel));

    // Register the state, the credit and every output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            credit       <= '0;
            done         <= 1'b0;
            change_pulse <= 1'b0;
            refunding    <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            credit       <= credit_next;
            done         <= done_next;
            change_pulse <= change_pulse_next;
            refunding    <= refunding_next;
            coin_reject  <= coin_reject_next;
            busy         <= busy_next;
        end
    end

    // Next state and next credit: collect, vend, then pay out in 25p steps.
    always_comb begin
        state_next  = state;
        credit_next = credit;
        case (state)
            IDLE, COLLECT: begin
                if ((state == COLLECT) && cancel) begin
                    state_next = REFUND;
                end else if (coin_accepted) begin
                    credit_next = credit_sum[CW-1:0];
                    state_next  = (credit_sum >= PRICE_WIDE) ? VEND : COLLECT;
                end
            end
            VEND: begin
                if (vend_ack) begin
                    credit_next = credit - PRICE_NARROW;
                    state_next  = (credit == PRICE_NARROW) ? IDLE : CHANGE;
                end
            end
            CHANGE, REFUND: begin
                if (credit == '0) begin
                    state_next = IDLE;
                end else begin
                    credit_next = credit - CHANGE_STEP;
                end
            end
            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    // Next output values, derived from the transition being taken.
    always_comb begin
        done_next         = (state_next == VEND);
        busy_next         = !((state_next == IDLE) || (state_next == COLLECT));
        refunding_next    = (state_next == REFUND);
        change_pulse_next = ((state == CHANGE) || (state == REFUND)) && (credit != '0);
        coin_reject_next  = coin_valid && !coin_accepted;
    end

endmodule

// File: tb/tb_coin_collector_chg.sv
// tb_coin_collector_chg: scoreboard bench for coin_collector_chg.
// Two instances (PRICE=100 and PRICE=150, both MAX_CREDIT=175) share one
// stimulus stream; a behavioural model predicts each one's outputs, the
// predictions are queued when stimulus is driven and checked after the edge.
module tb_coin_collector_chg;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_VEND    = 2;
    localparam int M_CHANGE  = 3;
    localparam int M_REFUND  = 4;

    typedef struct {
        int st;
        int cr;
        int dn;
        int cp;
        int rf;
        int rj;
        int bz;
    } model_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] coin;
    logic       cancel;
    logic       vend_ack;

    logic       done_a, change_pulse_a, refunding_a, coin_reject_a, busy_a;
    logic [7:0] credit_a;
    logic       done_b, change_pulse_b, refunding_b, coin_reject_b, busy_b;
    logic [7:0] credit_b;

    model_t model_a;
    model_t model_b;
    model_t exp_q_a[$];
    model_t exp_q_b[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    coin_collector_chg #(.PRICE(100), .MAX_CREDIT(175), .CW(8)) dut_a (
        .clock        (clock),
        .reset        (reset),
        .coin         (coin),
        .cancel       (cancel),
        .vend_ack     (vend_ack),
        .done         (done_a),
        .credit       (credit_a),
        .change_pulse (change_pulse_a),
        .refunding    (refunding_a),
        .coin_reject  (coin_reject_a),
        .busy         (busy_a)
    );

    coin_collector_chg #(.PRICE(150), .MAX_CREDIT(175), .CW(8)) dut_b (
        .clock        (clock),
        .reset        (reset),
        .coin         (coin),
        .cancel       (cancel),
        .vend_ack     (vend_ack),
        .done         (done_b),
        .credit       (credit_b),
        .change_pulse (change_pulse_b),
        .refunding    (refunding_b),
        .coin_reject  (coin_reject_b),
        .busy         (busy_b)
    );

    always #5 clock = ~clock;

    // Behavioural prediction of the outputs visible after one clock edge.
    function automatic model_t modelStep(input model_t m, input int price, input int max_credit,
                                         input logic rs, input logic [1:0] c,
                                         input logic cn, input logic ak);
        model_t n;
        int     value;
        value = (c == 2'b00) ? 25 : (c == 2'b01) ? 50 : (c == 2'b10) ? 100 : 0;
        n     = m;
        n.rj  = 0;
        n.cp  = 0;
        if (rs) begin
            n.st = M_IDLE;
            n.cr = 0;
        end else if (m.st == M_COLLECT && cn) begin
            n.st = M_REFUND;
            n.rj = (c != 2'b11) ? 1 : 0;
        end else if (m.st == M_IDLE || m.st == M_COLLECT) begin
            if (c != 2'b11) begin
                if (m.cr + value > max_credit) begin
                    n.rj = 1;
                end else begin
                    n.cr = m.cr + value;
                    n.st = (n.cr >= price) ? M_VEND : M_COLLECT;
                end
            end
        end else if (m.st == M_VEND) begin
            n.rj = (c != 2'b11) ? 1 : 0;
            if (ak) begin
                n.cr = m.cr - price;
                n.st = (n.cr == 0) ? M_IDLE : M_CHANGE;
            end
        end else begin
            n.rj = (c != 2'b11) ? 1 : 0;
            if (m.cr == 0) begin
                n.st = M_IDLE;
            end else begin
                n.cr = m.cr - 25;
                n.cp = 1;
            end
        end
        n.dn = (n.st == M_VEND) ? 1 : 0;
        n.bz = (n.st == M_VEND || n.st == M_CHANGE || n.st == M_REFUND) ? 1 : 0;
        n.rf = (n.st == M_REFUND) ? 1 : 0;
        return n;
    endfunction

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Compare one instance's outputs against a popped prediction.
    task automatic compareSet(input string name, input model_t e, input int cr, input int dn,
                              input int cp, input int rf, input int rj, input int bz);
        checkOutput($sformatf("%s.credit@%0d", name, cycle), cr, e.cr);
        checkOutput($sformatf("%s.done@%0d", name, cycle), dn, e.dn);
        checkOutput($sformatf("%s.change_pulse@%0d", name, cycle), cp, e.cp);
        checkOutput($sformatf("%s.refunding@%0d", name, cycle), rf, e.rf);
        checkOutput($sformatf("%s.coin_reject@%0d", name, cycle), rj, e.rj);
        checkOutput($sformatf("%s.busy@%0d", name, cycle), bz, e.bz);
    endtask

    // Drive one cycle of stimulus, queue predictions, check after the edge.
    task automatic applyStimulus(input logic rs, input logic [1:0] c, input logic cn, input logic ak);
        model_t e;
        @(negedge clock);
        reset    = rs;
        coin     = c;
        cancel   = cn;
        vend_ack = ak;
        model_a  = modelStep(model_a, 100, 175, rs, c, cn, ak);
        model_b  = modelStep(model_b, 150, 175, rs, c, cn, ak);
        exp_q_a.push_back(model_a);
        exp_q_b.push_back(model_b);
        @(posedge clock);
        #1;
        cycle++;
        e = exp_q_a.pop_front();
        compareSet("a", e, int'(credit_a), int'(done_a), int'(change_pulse_a),
                   int'(refunding_a), int'(coin_reject_a), int'(busy_a));
        e = exp_q_b.pop_front();
        compareSet("b", e, int'(credit_b), int'(done_b), int'(change_pulse_b),
                   int'(refunding_b), int'(coin_reject_b), int'(busy_b));
        if (change_pulse_a) pulses_a++;
        if (change_pulse_b) pulses_b++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
    endtask

    task automatic startScenario(input string name);
        $display("[TB] scenario %s", name);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
        pulses_a = 0;
        pulses_b = 0;
    endtask

    initial begin
        reset    = 1'b1;
        coin     = 2'b11;
        cancel   = 1'b0;
        vend_ack = 1'b0;
        model_a  = '{M_IDLE, 0, 0, 0, 0, 0, 0};
        model_b  = '{M_IDLE, 0, 0, 0, 0, 0, 0};

        // Reset state, then quiet idle with cancel/vend_ack having no effect.
        startScenario("reset");
        idleCycles(1);
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1);

        // Four 25p coins reach PRICE=100 exactly; vend leaves no change.
        startScenario("exact");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1);
        idleCycles(3);
        checkOutput("exact.pulses_a", pulses_a, 0);

        // 50p then 100p: 150 credit, vend then 50p change for PRICE=100.
        startScenario("change");
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1);
        idleCycles(4);
        checkOutput("change.pulses_a", pulses_a, 2);
        checkOutput("change.pulses_b", pulses_b, 0);

        // Cancel at 75 with a coin on the same edge: coin rejected, 3 refund pulses.
        startScenario("cancel");
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
        idleCycles(5);
        checkOutput("cancel.pulses_a", pulses_a, 3);
        checkOutput("cancel.pulses_b", pulses_b, 3);

        // Fill to MAX_CREDIT, coin during VEND rejected, cancel ignored, then accept again.
        startScenario("maxcredit");
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1);
        idleCycles(5);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        checkOutput("maxcredit.pulses_a", pulses_a, 3);
        checkOutput("maxcredit.pulses_b", pulses_b, 1);

        // Overflow: 100 + 100 exceeds 175 while collecting (PRICE=150 instance).
        startScenario("overflow");
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        idleCycles(1);

        // Reset on the second cycle of a 3-pulse change run discards the rest.
        startScenario("reset_mid_change");
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1);
        idleCycles(1);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
        idleCycles(3);
        checkOutput("reset_mid_change.pulses_a", pulses_a, 1);
        checkOutput("reset_mid_change.credit_a", int'(credit_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
